pixel_sequencer: RTL and testbench

PIXEL_SEQUENCER -- requirements
Module: pixel_sequencer

---
 rtl/pixel_seq_pkg.sv | 23 ++
 rtl/pixel_sequencer_if.sv | 32 +++
 rtl/pixel_sequencer_xy_counter.sv | 43 ++++
 rtl/pixel_sequencer.sv | 143 ++++++++++++++
 tb/tb_pixel_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pixel_seq_pkg.sv
// Shared types and constants for the pixel sequencer.
package pixel_seq_pkg;

  localparam int unsigned PixW = 8;
  localparam int unsigned BlankCycDefault = 4;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StBlank
  } seq_state_e;

  // First pixel of a frame: origin of the raster.
  function automatic logic is_frame_start(input logic [PixW-1:0] x, input logic [PixW-1:0] y);
    return (x == '0) && (y == '0);
  endfunction

  // First pixel of any line after the first.
  function automatic logic is_line_start(input logic [PixW-1:0] x, input logic [PixW-1:0] y);
    return (x == '0) && (y != '0);
  endfunction

endpackage

// File: rtl/pixel_sequencer_if.sv
// Control, pixel source and output stream signals of the pixel sequencer.
interface pixel_sequencer_if;
  import pixel_seq_pkg::*;

  logic            Start;
  logic            Abort;
  logic [PixW-1:0] Width;
  logic [PixW-1:0] Height;
  logic            SrcValid;
  logic [PixW-1:0] SrcPixel;
  logic            SrcReady;
  logic [PixW-1:0] PixelOut;
  logic            PixelValid;
  logic            FrameOut;
  logic            LineOut;
  logic            Busy;
  logic            Done;
  logic            Err;

  // Driver side: issues commands and source pixels, consumes the stream.
  modport master (
    output Start, Abort, Width, Height, SrcValid, SrcPixel,
    input  SrcReady, PixelOut, PixelValid, FrameOut, LineOut, Busy, Done, Err
  );

  // Sequencer side.
  modport slave (
    input  Start, Abort, Width, Height, SrcValid, SrcPixel,
    output SrcReady, PixelOut, PixelValid, FrameOut, LineOut, Busy, Done, Err
  );

endinterface

// File: rtl/pixel_sequencer_xy_counter.sv
// Raster position counter: x wraps at the latched width, y advances per wrap.
module xy_counter
  import pixel_seq_pkg::*;
(
  input  logic            Clk,
  input  logic            nReset,
  input  logic            step,
  input  logic            clear,
  input  logic [PixW-1:0] width,
  input  logic [PixW-1:0] height,
  output logic [PixW-1:0] x,
  output logic [PixW-1:0] y,
  output logic            line_end,
  output logic            frame_end
);

  logic [PixW-1:0] x_q;
  logic [PixW-1:0] y_q;

  assign x         = x_q;
  assign y         = y_q;
  assign line_end  = (x_q == width - PixW'(1));
  assign frame_end = line_end && (y_q == height - PixW'(1));

  // Advance one pixel per step; wrap at line end, and to the origin at frame end.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clear) begin
      x_q <= '0;
      y_q <= '0;
    end else if (step) begin
      if (line_end) begin
        x_q <= '0;
        y_q <= frame_end ? '0 : y_q + PixW'(1);
      end else begin
        x_q <= x_q + PixW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_sequencer.sv
// Pixel sequencer: pulls one frame of Width x Height pixels from a source and
// streams them to the Hough pipeline with frame/line sync flags.
// Optional inter-line blanking is compiled in with PIXEL_SEQ_BLANK_EN.
module pixel_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int unsigned BLANK_CYC = BlankCycDefault
) (
  input logic              Clk,
  input logic              nReset,
  pixel_sequencer_if.slave bus
);

  seq_state_e      state_q;
  logic [PixW-1:0] width_q;
  logic [PixW-1:0] height_q;
  logic [PixW-1:0] pixel_q;
  logic            pixel_valid_q;
  logic            frame_q;
  logic            line_q;
  logic            done_q;
  logic            err_q;

  logic [PixW-1:0] x;
  logic [PixW-1:0] y;
  logic            line_end;
  logic            frame_end;

  logic            dims_ok;
  logic            start_ok;
  logic            start_bad;
  logic            abort_hit;
  logic            src_ready;
  logic            xfer;

`ifdef PIXEL_SEQ_BLANK_EN
  localparam int unsigned CntW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  logic [CntW-1:0] blank_cnt_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^BLANK_CYC;
`endif

  // Command decode; Abort removes SrcReady in the same cycle so no transfer
  // can race it, which also gives it priority over the last-pixel transfer.
  always_comb begin
    dims_ok   = (bus.Width != '0) && (bus.Height != '0);
    start_ok  = (state_q == StIdle) && bus.Start && dims_ok;
    start_bad = (state_q == StIdle) && bus.Start && !dims_ok;
    abort_hit = (state_q != StIdle) && bus.Abort;
    src_ready = (state_q == StActive) && !bus.Abort;
    xfer      = src_ready && bus.SrcValid;
  end

  xy_counter u_xy_counter (
    .Clk       (Clk),
    .nReset    (nReset),
    .step      (xfer),
    .clear     (start_ok || abort_hit),
    .width     (width_q),
    .height    (height_q),
    .x         (x),
    .y         (y),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Sequencing FSM with registered stream and status outputs.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q       <= StIdle;
      width_q       <= '0;
      height_q      <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      frame_q       <= 1'b0;
      line_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef PIXEL_SEQ_BLANK_EN
      blank_cnt_q   <= '0;
`endif
    end else begin
      // Stream outputs follow the transfer by one cycle; PixelOut holds otherwise.
      pixel_valid_q <= xfer;
      frame_q       <= xfer && is_frame_start(x, y);
      line_q        <= xfer && is_line_start(x, y);
      done_q        <= xfer && frame_end;
      err_q         <= start_bad;
      if (xfer) begin
        pixel_q <= bus.SrcPixel;
      end

      unique case (state_q)
        StIdle: begin
          if (start_ok) begin
            width_q  <= bus.Width;
            height_q <= bus.Height;
            state_q  <= StActive;
          end
        end
        StActive: begin
          if (abort_hit) begin
            state_q <= StIdle;
          end else if (xfer && frame_end) begin
            state_q <= StIdle;
          end else if (xfer && line_end) begin
`ifdef PIXEL_SEQ_BLANK_EN
            if (BLANK_CYC != 0) begin
              state_q     <= StBlank;
              blank_cnt_q <= CntW'(BLANK_CYC - 1);
            end
`endif
          end
        end
        StBlank: begin
`ifdef PIXEL_SEQ_BLANK_EN
          if (abort_hit) begin
            state_q <= StIdle;
          end else if (blank_cnt_q == '0) begin
            state_q <= StActive;
          end else begin
            blank_cnt_q <= blank_cnt_q - CntW'(1);
          end
`else
          state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.SrcReady   = src_ready;
  assign bus.PixelOut   = pixel_q;
  assign bus.PixelValid = pixel_valid_q;
  assign bus.FrameOut   = frame_q;
  assign bus.LineOut    = line_q;
  assign bus.Busy       = (state_q != StIdle);
  assign bus.Done       = done_q;
  assign bus.Err        = err_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
// Scoreboard bench for pixel_sequencer: a raster-index model predicts each
// output pixel and its flags; a monitor compares them as the DUT emits them.
module tb_pixel_sequencer;

  localparam int unsigned BlankCyc = 4;
`ifdef PIXEL_SEQ_BLANK_EN
  localparam bit BlankEn = 1'b1;
`else
  localparam bit BlankEn = 1'b0;
`endif

  logic Clk = 1'b0;
  logic nReset;

  pixel_sequencer_if bus ();

  pixel_sequencer #(.BLANK_CYC(BlankCyc)) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0] pix;
    logic       fr;
    logic       ln;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: frame in progress, pixels accepted so far, blank cycles left.
  bit m_active = 0;
  int m_blank  = 0;
  bit m_err    = 0;
  int m_k      = 0;
  int m_w      = 1;
  int m_h      = 1;

  int pv_cnt, fr_cnt, ln_cnt, dn_cnt, busy_cnt;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock cycle: drive inputs after the edge, check and advance the model mid-cycle.
  task automatic step_cycle(input bit start, input bit abort, input bit valid);
    exp_t e;
    @(posedge Clk);
    #1;
    bus.Start    = start;
    bus.Abort    = abort;
    bus.SrcValid = valid;
    bus.SrcPixel = 8'($urandom);
    @(negedge Clk);
    if (bus.Busy) busy_cnt++;
    chk("busy", int'(bus.Busy), int'(m_active));
    chk("src_ready", int'(bus.SrcReady), int'(m_active && m_blank == 0 && !abort));
    chk("err", int'(bus.Err), int'(m_err));
    m_err = 0;
    if (m_active && abort) begin
      m_active = 0;
      m_blank  = 0;
    end else if (m_active) begin
      if (m_blank > 0) begin
        m_blank--;
      end else if (valid) begin
        e.pix = bus.SrcPixel;
        e.fr  = (m_k == 0);
        e.ln  = (m_k % m_w == 0) && (m_k != 0);
        e.dn  = (m_k == m_w * m_h - 1);
        exp_q.push_back(e);
        m_k++;
        if (m_k == m_w * m_h) m_active = 0;
        else if (BlankEn && (m_k % m_w == 0)) m_blank = BlankCyc;
      end
    end else if (start) begin
      if (bus.Width == 0 || bus.Height == 0) begin
        m_err = 1;
      end else begin
        m_active = 1;
        m_blank  = 0;
        m_k      = 0;
        m_w      = int'(bus.Width);
        m_h      = int'(bus.Height);
      end
    end
  endtask

  // Monitor: every emitted pixel must match the head of the scoreboard.
  always @(negedge Clk) begin
    if (nReset) begin
      if (bus.PixelValid) begin
        pv_cnt++;
        if (bus.FrameOut) fr_cnt++;
        if (bus.LineOut) ln_cnt++;
        if (bus.Done) dn_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pixel", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pixel_out", int'(bus.PixelOut), int'(mon_e.pix));
          chk("frame_out", int'(bus.FrameOut), int'(mon_e.fr));
          chk("line_out", int'(bus.LineOut), int'(mon_e.ln));
          chk("done", int'(bus.Done), int'(mon_e.dn));
        end
      end else begin
        chk("frame_out_idle", int'(bus.FrameOut), 0);
        chk("line_out_idle", int'(bus.LineOut), 0);
        chk("done_idle", int'(bus.Done), 0);
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pixel_out"}, int'(bus.PixelOut), 0);
    chk({tag, "_pixel_valid"}, int'(bus.PixelValid), 0);
    chk({tag, "_frame_out"}, int'(bus.FrameOut), 0);
    chk({tag, "_line_out"}, int'(bus.LineOut), 0);
    chk({tag, "_done"}, int'(bus.Done), 0);
    chk({tag, "_err"}, int'(bus.Err), 0);
    chk({tag, "_src_ready"}, int'(bus.SrcReady), 0);
    chk({tag, "_busy"}, int'(bus.Busy), 0);
  endtask

  // Run one frame; abort_k >= 0 aborts together with the transfer of pixel abort_k.
  task automatic run_frame(input int w, input int h, input int pct, input int stall_k,
                           input int abort_k, input bit stray, input string tag);
    int stall_left;
    bit ab, st, v;
    stall_left = 5;
    pv_cnt = 0; fr_cnt = 0; ln_cnt = 0; dn_cnt = 0; busy_cnt = 0;
    bus.Width  = 8'(w);
    bus.Height = 8'(h);
    step_cycle(1, 0, 0);
    for (int n = 0; n < 4000 && m_active; n++) begin
      ab = (abort_k >= 0) && (m_k == abort_k) && (m_blank == 0);
      st = stray && (n > 0) && ($urandom_range(0, 7) == 0);
      if (st) begin
        bus.Width  = 8'($urandom_range(0, 9));
        bus.Height = 8'($urandom_range(0, 9));
      end
      if (ab) v = 1;
      else if (m_k == stall_k && stall_left > 0) begin
        v = 0;
        stall_left--;
      end else v = ($urandom_range(1, 100) <= pct);
      step_cycle(st, ab, v);
    end
    chk({tag, "_frame_finished"}, int'(m_active), 0);
    if (m_active) step_cycle(0, 1, 0);
    step_cycle(0, 0, 0);
    step_cycle(0, 0, 0);
    chk({tag, "_pixel_count"}, pv_cnt, (abort_k >= 0) ? abort_k : w * h);
    chk({tag, "_done_count"}, dn_cnt, (abort_k >= 0) ? 0 : 1);
    if (abort_k < 0) begin
      chk({tag, "_frame_flags"}, fr_cnt, 1);
      chk({tag, "_line_flags"}, ln_cnt, h - 1);
    end
    chk({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    nReset       = 1'b0;
    bus.Start    = 1'b0;
    bus.Abort    = 1'b0;
    bus.Width    = '0;
    bus.Height   = '0;
    bus.SrcValid = 1'b0;
    bus.SrcPixel = '0;
    repeat (2) @(negedge Clk);
    check_reset_outputs("reset");
    nReset = 1'b1;

    // Full-rate 4x3 frame; blanking adds two gaps of BlankCyc.
    run_frame(4, 3, 100, -1, -1, 0, "w4h3");
    chk("w4h3_busy_cycles", busy_cnt, 12 + (BlankEn ? 2 * BlankCyc : 0));

    // Five-cycle source stall after the first pixel.
    run_frame(3, 2, 100, 1, -1, 0, "stall");

    // Zero dimensions are rejected with a single Err pulse.
    bus.Width = 8'd0; bus.Height = 8'd5;
    step_cycle(1, 0, 1);
    step_cycle(0, 0, 1);
    step_cycle(0, 0, 0);
    bus.Width = 8'd3; bus.Height = 8'd0;
    step_cycle(1, 0, 1);
    step_cycle(0, 0, 1);
    step_cycle(0, 0, 0);

    // Degenerate shapes.
    run_frame(1, 1, 100, -1, -1, 0, "w1h1");
    run_frame(1, 4, 100, -1, -1, 0, "w1h4");
    run_frame(5, 1, 60, -1, -1, 0, "w5h1");

    // Abort together with the last-pixel transfer, then at a random point.
    run_frame(3, 2, 100, -1, 5, 0, "abort_last");
    run_frame(4, 3, 70, -1, int'($urandom_range(0, 11)), 1, "abort_rand");

    // Random shapes, random source gaps, stray Start while busy.
    for (int i = 0; i < 8; i++) begin
      run_frame(int'($urandom_range(1, 6)), int'($urandom_range(1, 5)),
                int'($urandom_range(40, 100)), -1, -1, 1, "rand");
    end

    // Reset in the middle of a frame.
    bus.Width = 8'd5; bus.Height = 8'd4;
    step_cycle(1, 0, 1);
    repeat (6) step_cycle(0, 0, 1);
    @(posedge Clk);
    #1;
    nReset       = 1'b0;
    bus.Start    = 1'b0;
    bus.Abort    = 1'b0;
    bus.SrcValid = 1'b0;
    #2;
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    m_active = 0;
    m_blank  = 0;
    m_err    = 0;
    @(negedge Clk);
    nReset = 1'b1;
    // No pixels flow until a new Start.
    repeat (3) step_cycle(0, 0, 1);
    run_frame(4, 2, 80, -1, -1, 0, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
